// File: rtl/csm_pkg.sv
// Shared definitions for the two-port lock-protected register block:
// command opcodes, lock states and the owner output encoding.
package csm_pkg;

   typedef enum logic [1:0] {
      OpWrite   = 2'd0,
      OpRead    = 2'd1,
      OpHold    = 2'd2,
      OpRelease = 2'd3
   } op_e;

   localparam logic [1:0] OwnerFree = 2'd0;
   localparam logic [1:0] OwnerA    = 2'd1;
   localparam logic [1:0] OwnerB    = 2'd2;

   // State values double as the owner output encoding.
   typedef enum logic [1:0] {
      StFree  = OwnerFree,
      StAHold = OwnerA,
      StBHold = OwnerB
   } lock_e;

endpackage

// File: rtl/csm_regfile.sv
// Shared register array: two write ports (port A wins on an address clash)
// and two asynchronous read ports.
module csm_regfile
   import csm_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_waddr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_waddr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [ADDR_W-1:0] a_raddr,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_raddr,
   output logic [DATA_W-1:0] b_rdata
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [Depth];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (a_we) begin
            regs_q[a_waddr] <= a_wdata;
         end
         if (b_we && !(a_we && (a_waddr == b_waddr))) begin
            regs_q[b_waddr] <= b_wdata;
         end
      end
   end

   assign a_rdata = regs_q[a_raddr];
   assign b_rdata = regs_q[b_raddr];

endmodule

// File: rtl/csm_port_ctrl.sv
// Two-processor shared register block with a HOLD/RELEASE lock.
// Optional idle-owner forced release under macro CSM_HOLD_TIMEOUT_EN.
module csm_port_ctrl
   import csm_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned ADDR_W       = 2,
   parameter int unsigned HOLD_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic [1:0]        a_op,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_ack,
   output logic              a_err,
   input  logic              b_req,
   input  logic [1:0]        b_op,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_ack,
   output logic              b_err,
   output logic [1:0]        owner
);

   if (HOLD_TIMEOUT < 1) begin : gen_param_check
      $error("HOLD_TIMEOUT must be at least 1");
   end

   lock_e             state_q, state_d;
   logic              a_we, b_we;
   logic              a_grant, b_grant, a_rel, b_rel;
   logic              a_err_d, b_err_d;
   logic [DATA_W-1:0] a_rd, b_rd, a_rdata_d, b_rdata_d;
   logic              timeout;

   csm_regfile #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_we   (a_we),
      .a_waddr(a_addr),
      .a_wdata(a_wdata),
      .b_we   (b_we),
      .b_waddr(b_addr),
      .b_wdata(b_wdata),
      .a_raddr(a_addr),
      .a_rdata(a_rd),
      .b_raddr(b_addr),
      .b_rdata(b_rd)
   );

   // Both ports are judged against the lock state held before this cycle.
   always_comb begin
      a_we      = 1'b0;
      b_we      = 1'b0;
      a_grant   = 1'b0;
      b_grant   = 1'b0;
      a_rel     = 1'b0;
      b_rel     = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      a_rdata_d = '0;
      b_rdata_d = '0;

      if (a_req) begin
         if (state_q == StBHold) begin
            a_err_d = 1'b1;
         end else begin
            case (op_e'(a_op))
               OpWrite:   a_we = 1'b1;
               OpRead:    a_rdata_d = a_rd;
               OpHold:    a_grant = (state_q == StFree);
               OpRelease: begin
                  if (state_q == StAHold) a_rel = 1'b1;
                  else                    a_err_d = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (b_req) begin
         if (state_q == StAHold) begin
            b_err_d = 1'b1;
         end else begin
            case (op_e'(b_op))
               OpWrite: begin
                  if (a_we && (a_addr == b_addr)) b_err_d = 1'b1;
                  else                            b_we = 1'b1;
               end
               OpRead:    b_rdata_d = b_rd;
               OpHold: begin
                  if (state_q == StFree) begin
                     if (a_grant) b_err_d = 1'b1;
                     else         b_grant = 1'b1;
                  end
               end
               OpRelease: begin
                  if (state_q == StBHold) b_rel = 1'b1;
                  else                    b_err_d = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CSM_HOLD_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(HOLD_TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            held, owner_cmd;

   assign held      = (state_q != StFree);
   assign owner_cmd = ((state_q == StAHold) && a_req) || ((state_q == StBHold) && b_req);
   assign timeout   = held && !owner_cmd && (cnt_q == CntW'(HOLD_TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      if (held && !owner_cmd && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (a_grant) begin
         state_d = StAHold;
      end else if (b_grant) begin
         state_d = StBHold;
      end else if (a_rel || b_rel || timeout) begin
         state_d = StFree;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFree;
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         a_err   <= 1'b0;
         b_err   <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state_q <= state_d;
         a_ack   <= a_req;
         b_ack   <= b_req;
         a_err   <= a_err_d;
         b_err   <= b_err_d;
         a_rdata <= a_rdata_d;
         b_rdata <= b_rdata_d;
      end
   end

   assign owner = state_q;

endmodule

// File: tb/tb_csm_port_ctrl.sv
// Directed self-checking bench for csm_port_ctrl; the timeout steps follow
// whether CSM_HOLD_TIMEOUT_EN is defined.
module tb_csm_port_ctrl;

   localparam logic [1:0] W = 2'd0, R = 2'd1, H = 2'd2, L = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_req, b_req;
   logic [1:0] a_op, b_op;
   logic [1:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic [7:0] a_rdata, b_rdata;
   logic       a_ack, b_ack, a_err, b_err;
   logic [1:0] owner;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   csm_port_ctrl #(
      .DATA_W      (8),
      .ADDR_W      (2),
      .HOLD_TIMEOUT(16)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_req  (a_req),
      .a_op   (a_op),
      .a_addr (a_addr),
      .a_wdata(a_wdata),
      .a_rdata(a_rdata),
      .a_ack  (a_ack),
      .a_err  (a_err),
      .b_req  (b_req),
      .b_op   (b_op),
      .b_addr (b_addr),
      .b_wdata(b_wdata),
      .b_rdata(b_rdata),
      .b_ack  (b_ack),
      .b_err  (b_err),
      .owner  (owner)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic cmd_a(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] d);
      a_req = 1'b1; a_op = op; a_addr = addr; a_wdata = d;
   endtask

   task automatic cmd_b(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] d);
      b_req = 1'b1; b_op = op; b_addr = addr; b_wdata = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks one port's response: ack, err, rdata.
   task automatic chk_a(input string tag, input logic ack, input logic err, input logic [7:0] rd);
      chk({tag, ".a_ack"}, 32'(a_ack), 32'(ack));
      chk({tag, ".a_err"}, 32'(a_err), 32'(err));
      chk({tag, ".a_rdata"}, 32'(a_rdata), 32'(rd));
   endtask

   task automatic chk_b(input string tag, input logic ack, input logic err, input logic [7:0] rd);
      chk({tag, ".b_ack"}, 32'(b_ack), 32'(ack));
      chk({tag, ".b_err"}, 32'(b_err), 32'(err));
      chk({tag, ".b_rdata"}, 32'(b_rdata), 32'(rd));
   endtask

   initial begin
      rst_n = 1'b0;
      a_op = W; b_op = W; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
      // Commands during reset are dropped.
      cmd_a(W, 2'd1, 8'h33);
      cmd_b(R, 2'd0, 8'h00);
      tick();
      tick();
      chk_a("rst", 1'b0, 1'b0, 8'h00);
      chk_b("rst", 1'b0, 1'b0, 8'h00);
      chk("rst.owner", 32'(owner), 32'd0);
      idle();
      rst_n = 1'b1;
      tick();
      chk_a("rst_idle", 1'b0, 1'b0, 8'h00);

      // Write then read back the same address.
      cmd_a(W, 2'd1, 8'hA5);
      tick();
      chk_a("wr1", 1'b1, 1'b0, 8'h00);
      cmd_a(R, 2'd1, 8'h00);
      tick();
      chk_a("rd1", 1'b1, 1'b0, 8'hA5);
      idle();
      tick();
      chk_a("ack_one_cycle", 1'b0, 1'b0, 8'h00);

      // Read returns the pre-write value in the same cycle.
      cmd_a(W, 2'd1, 8'h3C);
      cmd_b(R, 2'd1, 8'h00);
      tick();
      chk_b("rd_before_wr", 1'b1, 1'b0, 8'hA5);
      idle();
      cmd_b(R, 2'd1, 8'h00);
      tick();
      chk_b("rd_after_wr", 1'b1, 1'b0, 8'h3C);

      // Same-address write clash: A wins, B errors.
      idle();
      cmd_a(W, 2'd2, 8'hFF);
      cmd_b(W, 2'd2, 8'h00);
      tick();
      chk_a("clash", 1'b1, 1'b0, 8'h00);
      chk_b("clash", 1'b1, 1'b1, 8'h00);
      idle();
      cmd_a(R, 2'd2, 8'h00);
      tick();
      chk_a("clash_rd", 1'b1, 1'b0, 8'hFF);

      // Different addresses: both stored.
      cmd_a(W, 2'd2, 8'h11);
      cmd_b(W, 2'd3, 8'h22);
      tick();
      chk_a("dual_wr", 1'b1, 1'b0, 8'h00);
      chk_b("dual_wr", 1'b1, 1'b0, 8'h00);
      cmd_a(R, 2'd2, 8'h00);
      cmd_b(R, 2'd3, 8'h00);
      tick();
      chk_a("dual_rd", 1'b1, 1'b0, 8'h11);
      chk_b("dual_rd", 1'b1, 1'b0, 8'h22);

      // Simultaneous HOLD: A granted.
      cmd_a(H, 2'd0, 8'h00);
      cmd_b(H, 2'd0, 8'h00);
      tick();
      chk_a("hold_tie", 1'b1, 1'b0, 8'h00);
      chk_b("hold_tie", 1'b1, 1'b1, 8'h00);
      chk("hold_tie.owner", 32'(owner), 32'd1);

      // Non-owner is locked out.
      idle();
      cmd_b(R, 2'd3, 8'h00);
      tick();
      chk_b("locked_rd", 1'b1, 1'b1, 8'h00);
      chk("locked_rd.owner", 32'(owner), 32'd1);
      cmd_b(W, 2'd3, 8'h99);
      tick();
      chk_b("locked_wr", 1'b1, 1'b1, 8'h00);
      cmd_b(L, 2'd0, 8'h00);
      cmd_a(H, 2'd0, 8'h00);
      tick();
      chk_b("locked_rel", 1'b1, 1'b1, 8'h00);
      chk_a("rehold", 1'b1, 1'b0, 8'h00);
      chk("rehold.owner", 32'(owner), 32'd1);

      // Owner releases; B then reads, and the blocked write left no mark.
      idle();
      cmd_a(L, 2'd0, 8'h00);
      tick();
      chk_a("release", 1'b1, 1'b0, 8'h00);
      chk("release.owner", 32'(owner), 32'd0);
      idle();
      cmd_b(R, 2'd3, 8'h00);
      tick();
      chk_b("post_rel_rd", 1'b1, 1'b0, 8'h22);
      chk("post_rel.owner", 32'(owner), 32'd0);
      idle();
      cmd_a(L, 2'd0, 8'h00);
      tick();
      chk_a("rel_free", 1'b1, 1'b1, 8'h00);

      // B grant and A write in the same cycle: A judged against FREE.
      idle();
      cmd_b(H, 2'd0, 8'h00);
      cmd_a(W, 2'd0, 8'h5A);
      tick();
      chk_a("grant_cycle_wr", 1'b1, 1'b0, 8'h00);
      chk_b("grant_cycle_hold", 1'b1, 1'b0, 8'h00);
      chk("grant_cycle.owner", 32'(owner), 32'd2);
      cmd_a(R, 2'd0, 8'h00);
      cmd_b(R, 2'd0, 8'h00);
      tick();
      chk_a("b_held_a_rd", 1'b1, 1'b1, 8'h00);
      chk_b("b_held_b_rd", 1'b1, 1'b0, 8'h5A);
      idle();
      cmd_b(L, 2'd0, 8'h00);
      tick();
      chk_b("b_release", 1'b1, 1'b0, 8'h00);
      chk("b_release.owner", 32'(owner), 32'd0);

      // Idle owner for HOLD_TIMEOUT cycles.
      idle();
      cmd_a(H, 2'd0, 8'h00);
      tick();
      chk("to_hold.owner", 32'(owner), 32'd1);
      idle();
      for (int i = 0; i < 15; i++) begin
         tick();
      end
      chk("to_15.owner", 32'(owner), 32'd1);
      tick();
`ifdef CSM_HOLD_TIMEOUT_EN
      chk("to_16.owner", 32'(owner), 32'd0);
      cmd_b(W, 2'd0, 8'h77);
      tick();
      chk_b("to_b_wr", 1'b1, 1'b0, 8'h00);
`else
      chk("to_16.owner", 32'(owner), 32'd1);
      cmd_b(W, 2'd0, 8'h77);
      tick();
      chk_b("to_b_wr", 1'b1, 1'b1, 8'h00);
      idle();
      cmd_a(L, 2'd0, 8'h00);
      tick();
      chk("to_rel.owner", 32'(owner), 32'd0);
`endif

      // Reset mid-stream clears registers and drops the command.
      idle();
      rst_n = 1'b0;
      cmd_a(W, 2'd1, 8'hEE);
      tick();
      chk_a("rst2", 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      idle();
      cmd_a(R, 2'd1, 8'h00);
      tick();
      chk_a("rst2_rd", 1'b1, 1'b0, 8'h00);
      chk("rst2.owner", 32'(owner), 32'd0);
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
